// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO scheduler: byte width and drain states.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_FETCH   = 2'd1,
    SCHED_PRESENT = 2'd2,
    SCHED_POP     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/uart_fifo_sched_if.sv
// Bundle of requester, FIFO and transmitter signals around the scheduler.
// slave  = the scheduler's view, master = the surrounding system.
interface uart_fifo_sched_if;
  import uart_pkg::*;

  logic              enable;
  logic              clear_flags;
  logic              a_valid;
  logic [BYTE_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [BYTE_W-1:0] b_data;
  logic              b_ready;
  logic              fifo_write_strobe;
  logic [BYTE_W-1:0] fifo_write_data;
  logic [31:0]       fifo_write_available;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_read_strobe;
  logic [BYTE_W-1:0] fifo_read_data;
  logic              fifo_overflow;
  logic              fifo_underflow;
  logic              tx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_ready;
  logic              overflow_seen;
  logic              underflow_seen;
  logic [31:0]       tx_count;

  modport slave (
    input  enable, clear_flags, a_valid, a_data, b_valid, b_data,
           fifo_write_available, fifo_full, fifo_empty, fifo_read_data,
           fifo_overflow, fifo_underflow, tx_ready,
    output a_ready, b_ready, fifo_write_strobe, fifo_write_data,
           fifo_read_strobe, tx_valid, tx_data, overflow_seen,
           underflow_seen, tx_count
  );

  modport master (
    output enable, clear_flags, a_valid, a_data, b_valid, b_data,
           fifo_write_available, fifo_full, fifo_empty, fifo_read_data,
           fifo_overflow, fifo_underflow, tx_ready,
    input  a_ready, b_ready, fifo_write_strobe, fifo_write_data,
           fifo_read_strobe, tx_valid, tx_data, overflow_seen,
           underflow_seen, tx_count
  );

endinterface

// File: rtl/uart_rr_arb2.sv
// Two-input round-robin grant with per-input enable. Grants are combinational;
// only the "last served was B" bit is stored, and it moves only on a grant
// (a grant always coincides with a completed transfer).
module uart_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_en_a,
  input  logic i_en_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_last_b;
  logic w_ra;
  logic w_rb;

  assign w_ra    = i_req_a & i_en_a;
  assign w_rb    = i_req_b & i_en_b;
  assign o_gnt_a = !rst && w_ra && (!w_rb || r_last_b);
  assign o_gnt_b = !rst && w_rb && (!w_ra || !r_last_b);

  // Remember who was served last; reset to B so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (o_gnt_a) begin
      r_last_b <= 1'b0;
    end else if (o_gnt_b) begin
      r_last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_sched.sv
// Write-side arbiter and read-side drain sequencer for a uart_fifo.
//
//   state         | meaning
//   SCHED_IDLE    | waiting for enable && FIFO non-empty
//   SCHED_FETCH   | one cycle for the registered BRAM read data
//   SCHED_PRESENT | byte latched, tx_valid high until tx_ready
//   SCHED_POP     | fifo_read_strobe high for one cycle
module uart_fifo_sched
  import uart_pkg::*;
#(
  parameter int RESERVE = 4
) (
  input logic          clk,
  input logic          rst,
  uart_fifo_sched_if.slave bus
);

  localparam logic [31:0] A_THRESH = 32'(RESERVE + 1);

  sched_state_e      r_state;
  logic              r_tx_valid;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_rd_strobe;
  logic [31:0]       r_tx_count;
  logic              r_ovf_seen;
  logic              r_udf_seen;

  logic w_a_ok;
  logic w_b_ok;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_accept;

  // A keeps RESERVE entries free for B's priority traffic.
  assign w_b_ok = !bus.fifo_full;
  assign w_a_ok = !bus.fifo_full && (bus.fifo_write_available > A_THRESH);

  uart_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req_a (bus.a_valid),
    .i_req_b (bus.b_valid),
    .i_en_a  (w_a_ok),
    .i_en_b  (w_b_ok),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign bus.a_ready           = w_gnt_a;
  assign bus.b_ready           = w_gnt_b;
  assign bus.fifo_write_strobe = w_gnt_a | w_gnt_b;
  assign bus.fifo_write_data   = w_gnt_a ? bus.a_data :
                                 w_gnt_b ? bus.b_data : '0;

  assign w_accept = (r_state == SCHED_PRESENT) && bus.tx_ready;

  assign bus.tx_valid         = r_tx_valid;
  assign bus.tx_data          = r_tx_data;
  assign bus.fifo_read_strobe = r_rd_strobe;
  assign bus.tx_count         = r_tx_count;
  assign bus.overflow_seen    = r_ovf_seen;
  assign bus.underflow_seen   = r_udf_seen;

  // Drain sequencer with registered outputs and the sent-byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCHED_IDLE;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_rd_strobe <= 1'b0;
      r_tx_count  <= '0;
    end else begin
      r_rd_strobe <= 1'b0;
      case (r_state)
        SCHED_IDLE: begin
          if (bus.enable && !bus.fifo_empty) r_state <= SCHED_FETCH;
        end
        SCHED_FETCH: begin
          r_tx_data  <= bus.fifo_read_data;
          r_tx_valid <= 1'b1;
          r_state    <= SCHED_PRESENT;
        end
        SCHED_PRESENT: begin
          // The head entry is popped only after the transmitter took it.
          if (bus.tx_ready) begin
            r_tx_valid  <= 1'b0;
            r_rd_strobe <= 1'b1;
            r_state     <= SCHED_POP;
          end
        end
        SCHED_POP: begin
          r_state <= SCHED_IDLE;
        end
        default: r_state <= SCHED_IDLE;
      endcase

      if (bus.clear_flags) begin
        r_tx_count <= {31'd0, w_accept};
      end else if (w_accept) begin
        r_tx_count <= r_tx_count + 32'd1;
      end
    end
  end

  // Sticky FIFO error flags; a pulse coinciding with clear still sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_seen <= 1'b0;
      r_udf_seen <= 1'b0;
    end else begin
      r_ovf_seen <= (r_ovf_seen && !bus.clear_flags) || bus.fifo_overflow;
      r_udf_seen <= (r_udf_seen && !bus.clear_flags) || bus.fifo_underflow;
    end
  end

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Bench for uart_fifo_sched: behavioural FIFO environment, directed scenarios,
// a randomized phase, and a per-cycle reference model of arbitration rules,
// byte ordering, tx_count and sticky flags.
module tb_uart_fifo_sched;

  localparam int DEPTH   = 16;
  localparam int RESERVE = 4;

  logic clk;
  logic rst;
  logic fifo_rst;
  logic inj_ovf;
  logic inj_udf;

  int n_checks = 0;
  int n_errors = 0;

  uart_fifo_sched_if bus ();

  uart_fifo_sched #(.RESERVE(RESERVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural FIFO (environment) ----------------
  logic [7:0] f_mem [DEPTH];
  int         f_wp, f_rp, f_count;
  logic [7:0] f_rdata;
  logic       f_wr, f_rd;

  assign f_wr = bus.fifo_write_strobe && (f_count < DEPTH);
  assign f_rd = bus.fifo_read_strobe && (f_count > 0);

  always @(posedge clk) begin
    if (fifo_rst) begin
      f_wp <= 0; f_rp <= 0; f_count <= 0; f_rdata <= 8'h00;
    end else begin
      f_rdata <= f_mem[f_rp];
      if (f_wr) begin
        f_mem[f_wp] <= bus.fifo_write_data;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      if (f_rd) f_rp <= (f_rp + 1) % DEPTH;
      f_count <= f_count + (f_wr ? 1 : 0) - (f_rd ? 1 : 0);
    end
  end

  assign bus.fifo_full            = (f_count == DEPTH);
  assign bus.fifo_empty           = (f_count == 0);
  assign bus.fifo_write_available = 32'(DEPTH - f_count);
  assign bus.fifo_read_data       = f_rdata;
  assign bus.fifo_overflow        = inj_ovf;
  assign bus.fifo_underflow       = inj_udf;

  // ---------------- reference model ----------------
  bit         mon_en = 0;
  logic [7:0] sb[$];
  int         m_count = 0;
  bit         m_ovf = 0, m_udf = 0;
  bit         m_last_b = 1;
  bit         m_hold = 0;
  logic [7:0] m_hold_data = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      bit a_ok, b_ok, ra, rb, win_a, win_b, acc;
      check_val("tx_count", bus.tx_count, 32'(m_count));
      check_val("ovf_seen", {31'd0, bus.overflow_seen}, {31'd0, m_ovf});
      check_val("udf_seen", {31'd0, bus.underflow_seen}, {31'd0, m_udf});
      if (m_hold) begin
        check_val("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
        check_val("hold_data", {24'd0, bus.tx_data}, {24'd0, m_hold_data});
      end
      if (bus.fifo_read_strobe) check_val("pop_when_empty", 32'(f_count == 0), 32'd0);
      check_val("ready_excl", {31'd0, bus.a_ready & bus.b_ready}, 32'd0);

      b_ok = (f_count < DEPTH);
      a_ok = (f_count < DEPTH) && ((DEPTH - f_count) > RESERVE + 1);
      ra = bus.a_valid && a_ok;
      rb = bus.b_valid && b_ok;
      win_a = 0; win_b = 0;
      if (ra && rb) begin
        if (m_last_b) win_a = 1; else win_b = 1;
      end else if (ra) win_a = 1;
      else if (rb) win_b = 1;
      check_val("a_ready", {31'd0, bus.a_ready}, {31'd0, win_a});
      check_val("b_ready", {31'd0, bus.b_ready}, {31'd0, win_b});
      check_val("wr_strobe", {31'd0, bus.fifo_write_strobe}, {31'd0, win_a | win_b});
      check_val("wr_data", {24'd0, bus.fifo_write_data},
                {24'd0, win_a ? bus.a_data : (win_b ? bus.b_data : 8'h00)});
      if (win_a) begin sb.push_back(bus.a_data); m_last_b = 0; end
      if (win_b) begin sb.push_back(bus.b_data); m_last_b = 1; end

      acc = bus.tx_valid && bus.tx_ready;
      if (acc) begin
        if (sb.size() == 0) check_val("tx_unexpected", 32'd1, 32'd0);
        else check_val("tx_data", {24'd0, bus.tx_data}, {24'd0, sb.pop_front()});
      end
      if (bus.clear_flags) m_count = acc ? 1 : 0;
      else if (acc) m_count = m_count + 1;
      m_ovf = (m_ovf && !bus.clear_flags) || inj_ovf;
      m_udf = (m_udf && !bus.clear_flags) || inj_udf;
      m_hold = bus.tx_valid && !bus.tx_ready;
      m_hold_data = bus.tx_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (f_count == 0 && sb.size() == 0 && !bus.tx_valid) done = 1;
    end
    check_val(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_tx_valid(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1;
    end
    check_val(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rec[$];
    logic [7:0] exp_order [8];
    int ia, ib, acc_n;
    bit found;

    rst = 1; fifo_rst = 1; inj_ovf = 0; inj_udf = 0;
    bus.enable = 0; bus.clear_flags = 0; bus.tx_ready = 0;
    bus.a_valid = 1; bus.a_data = 8'h11; bus.b_valid = 1; bus.b_data = 8'h22;
    repeat (3) @(negedge clk);
    check_val("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check_val("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check_val("rst_tx_count", bus.tx_count, 32'd0);
    check_val("rst_flags", {30'd0, bus.overflow_seen, bus.underflow_seen}, 32'd0);
    check_val("rst_pop", {31'd0, bus.fifo_read_strobe}, 32'd0);
    check_val("rst_readies", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
    check_val("rst_wr", {23'd0, bus.fifo_write_strobe, bus.fifo_write_data}, 32'd0);
    tick();
    bus.a_valid = 0; bus.b_valid = 0;
    rst = 0; fifo_rst = 0;
    mon_en = 1;

    // Alternation from reset: A wins the first tie.
    for (int i = 0; i < 4; i++) begin
      exp_order[2*i]   = 8'hA0 + 8'(i);
      exp_order[2*i+1] = 8'hB0 + 8'(i);
    end
    ia = 0; ib = 0;
    for (int c = 0; c < 20 && (ia < 4 || ib < 4); c++) begin
      tick();
      bus.a_valid = (ia < 4); bus.a_data = 8'hA0 + 8'(ia);
      bus.b_valid = (ib < 4); bus.b_data = 8'hB0 + 8'(ib);
      @(negedge clk);
      if (bus.a_ready) begin rec.push_back(bus.a_data); ia++; end
      if (bus.b_ready) begin rec.push_back(bus.b_data); ib++; end
    end
    tick();
    bus.a_valid = 0; bus.b_valid = 0;
    check_val("rr_len", 32'(rec.size()), 32'd8);
    for (int i = 0; i < 8 && i < rec.size(); i++)
      check_val("rr_order", {24'd0, rec[i]}, {24'd0, exp_order[i]});
    bus.enable = 1; bus.tx_ready = 1;
    wait_drain("rr_drain", 100);
    repeat (2) tick();

    // Single byte latency through an empty FIFO.
    bus.a_valid = 1; bus.a_data = 8'h41;
    @(negedge clk);
    check_val("lat_a_ready", {31'd0, bus.a_ready}, 32'd1);
    check_val("lat_strobe", {31'd0, bus.fifo_write_strobe}, 32'd1);
    tick();
    bus.a_valid = 0;
    @(negedge clk); check_val("lat_idle", {31'd0, bus.tx_valid}, 32'd0);
    @(negedge clk); check_val("lat_fetch", {31'd0, bus.tx_valid}, 32'd0);
    @(negedge clk); check_val("lat_present", {31'd0, bus.tx_valid}, 32'd1);
    check_val("lat_data", {24'd0, bus.tx_data}, 32'h41);
    @(negedge clk); check_val("lat_pop", {31'd0, bus.fifo_read_strobe}, 32'd1);
    @(negedge clk); check_val("lat_pop_once", {31'd0, bus.fifo_read_strobe}, 32'd0);
    check_val("lat_count", bus.tx_count, 32'd9);

    // Reserve threshold, full FIFO, stalled transmitter.
    tick();
    bus.enable = 0; bus.tx_ready = 0;
    bus.b_valid = 1; bus.b_data = 8'($urandom);
    for (int c = 0; c < 30 && f_count < DEPTH - RESERVE - 1; c++) begin
      tick();
      bus.b_data = 8'($urandom);
    end
    check_val("res_level", 32'(f_count), 32'(DEPTH - RESERVE - 1));
    bus.a_valid = 1; bus.a_data = 8'h5A;
    @(negedge clk);
    check_val("res_a_blocked", {31'd0, bus.a_ready}, 32'd0);
    check_val("res_b_granted", {31'd0, bus.b_ready}, 32'd1);
    for (int c = 0; c < 30 && f_count < DEPTH; c++) begin
      tick();
      bus.b_data = 8'($urandom);
    end
    @(negedge clk);
    check_val("full_readies", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
    check_val("full_strobe", {31'd0, bus.fifo_write_strobe}, 32'd0);
    tick();
    bus.b_valid = 0;
    bus.enable = 1;
    wait_tx_valid("stall_present", 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("stall_data", {24'd0, bus.tx_data}, {24'd0, sb[0]});
      check_val("stall_nopop", {31'd0, bus.fifo_read_strobe}, 32'd0);
    end
    tick();
    bus.tx_ready = 1;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (bus.a_ready) begin
        found = 1;
        check_val("res_resume_level", 32'(f_count), 32'(DEPTH - RESERVE - 2));
      end
    end
    check_val("res_resume_seen", {31'd0, found}, 32'd1);
    tick();
    bus.a_valid = 0;
    wait_drain("res_drain", 150);

    // Enable gating with three queued bytes.
    tick();
    bus.clear_flags = 1; bus.enable = 0;
    tick();
    bus.clear_flags = 0;
    bus.a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.a_data = 8'h30 + 8'(i);
      tick();
    end
    bus.a_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("en_nopop", {31'd0, bus.fifo_read_strobe}, 32'd0);
      check_val("en_novalid", {31'd0, bus.tx_valid}, 32'd0);
    end
    tick();
    bus.enable = 1; bus.tx_ready = 1;
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) acc_n++;
    end
    check_val("en_sent12", 32'(acc_n), 32'd3);
    check_val("en_count", bus.tx_count, 32'd3);

    // Sticky flags.
    tick();
    inj_udf = 1;
    tick();
    inj_udf = 0;
    @(negedge clk);
    check_val("udf_sticky", {30'd0, bus.overflow_seen, bus.underflow_seen}, 32'd1);
    tick();
    inj_ovf = 1; bus.clear_flags = 1;
    tick();
    inj_ovf = 0; bus.clear_flags = 0;
    @(negedge clk);
    check_val("ovf_set_wins", {30'd0, bus.overflow_seen, bus.underflow_seen}, 32'd2);

    // clear_flags coinciding with an accept.
    tick();
    bus.tx_ready = 0; bus.a_valid = 1; bus.a_data = 8'h77;
    tick();
    bus.a_valid = 0;
    wait_tx_valid("clr_present", 10);
    tick();
    bus.tx_ready = 1; bus.clear_flags = 1;
    tick();
    bus.clear_flags = 0;
    @(negedge clk);
    check_val("clr_accept_count", bus.tx_count, 32'd1);
    wait_drain("clr_drain", 20);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      tick();
      bus.a_valid     = 1'($urandom_range(0, 1));
      bus.a_data      = 8'($urandom);
      bus.b_valid     = ($urandom_range(0, 2) == 0);
      bus.b_data      = 8'($urandom);
      bus.enable      = ($urandom_range(0, 7) != 0);
      bus.tx_ready    = ($urandom_range(0, 3) != 0);
      bus.clear_flags = ($urandom_range(0, 40) == 0);
      inj_ovf         = ($urandom_range(0, 60) == 0);
      inj_udf         = ($urandom_range(0, 60) == 0);
    end
    tick();
    bus.a_valid = 0; bus.b_valid = 0; bus.enable = 1; bus.tx_ready = 1;
    bus.clear_flags = 0; inj_ovf = 0; inj_udf = 0;
    wait_drain("rand_drain", 200);

    // Reset while a byte is presented.
    tick();
    bus.tx_ready = 0; bus.a_valid = 1; bus.a_data = 8'hC3;
    tick();
    bus.a_valid = 0;
    wait_tx_valid("rst_present", 10);
    mon_en = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    check_val("rstmid_valid", {31'd0, bus.tx_valid}, 32'd0);
    check_val("rstmid_pop", {31'd0, bus.fifo_read_strobe}, 32'd0);
    bus.tx_ready = 1;
    repeat (2) begin
      @(negedge clk);
      check_val("rstmid_nopop", {31'd0, bus.fifo_read_strobe}, 32'd0);
    end
    tick();
    bus.enable = 0;
    rst = 0;
    m_count = 0; m_ovf = 0; m_udf = 0; m_last_b = 1; m_hold = 0;
    mon_en = 1;
    repeat (2) @(negedge clk);
    check_val("rstmid_head_kept", 32'(f_count), 32'd1);
    tick();
    bus.enable = 1;
    wait_drain("rstmid_drain", 20);
    check_val("rstmid_count", bus.tx_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_sched.md
# uart_fifo_sched

Write-side arbiter and read-side sequencer for a `uart_fifo` instance. Two byte producers share the FIFO write port:
- requester A: bulk/host traffic, throttled by a headroom reserve;
- requester B: priority/echo traffic.

The drain side pops bytes, accounting for the FIFO's one-cycle BRAM read latency, and presents them to a UART transmitter over a valid/ready handshake. It sits between the bus-side writers, `uart_fifo`, and the TX shifter. It also exposes sticky FIFO error flags and a sent-byte counter.

## Interface
- `RESERVE`, default 4: FIFO entries withheld from A so that B always has headroom.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  drain enable. Low stops new pops; a byte already presented completes.
- `clear_flags`  in  1  one-cycle pulse; clears the sticky flags and `tx_count`.
- `a_valid`, `a_data[7:0]`, `a_ready`  in/in/out  requester A handshake.
- `b_valid`, `b_data[7:0]`, `b_ready`  in/in/out  requester B handshake.
- `fifo_write_strobe`  out  1  to `uart_fifo.write_strobe`.
- `fifo_write_data`  out  8  to `uart_fifo.write_data`.
- `fifo_write_available`  in  32  from `uart_fifo.write_available`.
- `fifo_full`, `fifo_empty`  in  1  from `uart_fifo`.
- `fifo_read_strobe`  out  1  to `uart_fifo.read_strobe`.
- `fifo_read_data`  in  8  from `uart_fifo.read_data`. Registered BRAM output: valid 1 cycle after the read address changes.
- `fifo_overflow`, `fifo_underflow`  in  1  single-cycle pulses from `uart_fifo`.
- `tx_valid`, `tx_data[7:0]`, `tx_ready`  out/out/in  transmitter handshake.
- `overflow_seen`, `underflow_seen`  out  1  sticky error flags.
- `tx_count`  out  32  bytes accepted by the transmitter since reset or the last clear.

## Operation
- **Write arbitration** is combinational, with one registered `last_b` bit for round-robin.
  - `b_ok = !fifo_full`.
  - `a_ok = !fifo_full && fifo_write_available > RESERVE+1`.
  - When both requesters are valid and permitted, the one not served last wins.
  - `a_ready`/`b_ready` are asserted only for the granted requester, and are never both high.
  - `fifo_write_strobe` = granted && valid. `fifo_write_data` = the winner's data, else 0.
  - `last_b` updates only on a completed transfer.
- **Drain FSM**, states IDLE, FETCH, PRESENT, POP:
  - IDLE → FETCH when `enable && !fifo_empty`.
  - FETCH: one wait cycle for BRAM data → PRESENT. On entry to PRESENT, latch `tx_data <= fifo_read_data`.
  - PRESENT: `tx_valid=1`. On `tx_ready`, go to POP and increment `tx_count`.
  - POP: `fifo_read_strobe=1` for exactly one cycle → IDLE.
  - `enable` is sampled only in IDLE.
  - `tx_data`/`tx_valid` must not change while `tx_valid && !tx_ready`.
- **Invariants:**
  - No pop is issued when `fifo_empty`.
  - No write is issued when `fifo_full`, so the FIFO's simultaneous full+read+write case is never exercised.
- **Error flags:**
  - `overflow_seen`/`underflow_seen` are set on the respective FIFO pulse.
  - `clear_flags` clears them. If a pulse and `clear_flags` coincide, set wins.
- **`tx_count`:** wraps modulo 2^32. `clear_flags` zeroes it. If an increment coincides with `clear_flags`, the result is 1.

## Timing
- **Reset values:** state IDLE; `tx_valid` 0; `tx_data` 0; `tx_count` 0; both flags 0; `last_b` 1 (A wins first tie); `fifo_read_strobe` 0.
- All combinational outputs (`a_ready`, `b_ready`, `fifo_write_*`) are 0 while `rst` is high.
- **Write latency:** the FIFO write occurs on the same edge as the requester handshake.
- **Drain latency:** non-empty FIFO in IDLE → `tx_valid` rises 2 cycles later (FETCH, then PRESENT).
- **Throughput:** minimum 4 cycles per byte with `tx_ready` held high.
- **Reset mid-operation:** asynchronous return to IDLE. A presented byte is dropped without a pop and remains at the FIFO head. The FIFO is reset separately.

## Structure
- A shared package `uart_pkg` holds the drain state encoding (`SCHED_IDLE`, `SCHED_FETCH`, `SCHED_PRESENT`, `SCHED_POP`) and the byte width constant.
- Natural sub-module: `uart_rr_arb2`, the two-input round-robin grant with per-input enable.
- The FIFO is instantiated by the parent, not inside this block.

## Test plan
- **Empty FIFO, A writes 0x41:** strobe on the same cycle; `tx_valid` rises 2 cycles after write_available shows the byte; `tx_data=0x41`; `fifo_read_strobe` pulses once after `tx_ready`; `tx_count=1`.
- **A and B valid continuously with 0xA0..0xA3 and 0xB0..0xB3:** FIFO order is A0,B0,A1,B1,…; no cycle with both readies high.
- **`fifo_write_available` = `RESERVE+1`, both valid:** only B granted; A stalls until a pop raises available to `RESERVE+2`.
- **`fifo_full`=1:** both readies 0, no write strobe. **`tx_ready` held 0 for 10 cycles:** `tx_data` stable and no pop.
- **`enable`=0 with 3 bytes queued:** no pops. Raise `enable`: 3 bytes sent in 12 cycles with `tx_ready`=1; `tx_count=3`.
- **Inject `fifo_underflow` pulse:** `underflow_seen` sticks. **`clear_flags` coinciding with a `tx_ready` accept:** `tx_count=1`. **`rst` asserted in PRESENT:** `tx_valid` 0 immediately, no `fifo_read_strobe`.
